// File: rtl/alu_iter.sv
// Iterative ALU for the EX stage: single-cycle logic/add/shift ops plus radix-2
// multiply and restoring divide, with a registered result behind valid/ready.
module alu_iter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             dbz,
  output logic [1:0]       state_dbg
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLL   = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SRL   = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_SRA   = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] reg_a, reg_hi, reg_lo;
  logic [SHW-1:0]   cnt;
  logic             neg_q, neg_r;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Input side is ready only in IDLE with the output slot empty or draining
  // on the same edge; out_valid and all result fields hold until out_ready.
  logic accept;
  assign in_ready  = (state == S_IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  logic is_mul, is_div, div_zero, sgn_op;
  assign is_mul   = (ctrl == OP_MULT) || (ctrl == OP_MULTU);
  assign is_div   = (ctrl == OP_DIV) || (ctrl == OP_DIVU);
  assign div_zero = is_div && (in2 == '0);
  assign sgn_op   = (ctrl == OP_MULT) || (ctrl == OP_DIV);

  logic [WIDTH-1:0] mag1, mag2;
  assign mag1 = (sgn_op && in1[WIDTH-1]) ? -in1 : in1;
  assign mag2 = (sgn_op && in2[WIDTH-1]) ? -in2 : in2;

  logic [WIDTH-1:0] add_sum, sub_diff, res_lo, res_hi;
  logic             res_ovf, res_dbz, slt;
  assign add_sum  = in1 + in2;
  assign sub_diff = in1 - in2;
  assign slt      = $signed(in1) < $signed(in2);

  always_comb begin
    res_lo  = '0;
    res_hi  = '0;
    res_ovf = 1'b0;
    res_dbz = 1'b0;
    case (ctrl)
      OP_AND: res_lo = in1 & in2;
      OP_OR:  res_lo = in1 | in2;
      OP_NOR: res_lo = ~(in1 | in2);
      OP_ADD, OP_ADDI: begin
        res_lo  = add_sum;
        res_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_sum[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB: begin
        res_lo  = sub_diff;
        res_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_diff[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SLT: res_lo = {{(WIDTH-1){1'b0}}, slt};
      OP_SLL: res_lo = in2 << shamt;
      OP_SRL: res_lo = in2 >> shamt;
      OP_SRA: res_lo = $signed(in2) >>> shamt;
      OP_DIV, OP_DIVU: begin
        // only reaches the result register when the divisor is zero
        res_lo  = '1;
        res_hi  = in1;
        res_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift-add step: reg_a multiplicand, reg_lo multiplier shifting out LSB first.
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi_next, mul_lo_next;
  logic [2*WIDTH-1:0] mul_prod, mul_fixed;
  assign mul_sum     = {1'b0, reg_hi} + (reg_lo[0] ? {1'b0, reg_a} : '0);
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], reg_lo[WIDTH-1:1]};
  assign mul_prod    = {mul_hi_next, mul_lo_next};
  assign mul_fixed   = neg_q ? -mul_prod : mul_prod;

  // Restoring step: reg_a divisor, reg_hi partial remainder, reg_lo dividend/quotient.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem_next, div_q_next, q_fixed, r_fixed;
  assign div_shift    = {reg_hi, reg_lo[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, reg_a};
  assign div_ok       = !div_diff[WIDTH];
  assign div_rem_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_q_next   = {reg_lo[WIDTH-2:0], div_ok};
  assign q_fixed      = neg_q ? -div_q_next : div_q_next;
  assign r_fixed      = neg_r ? -div_rem_next : div_rem_next;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && is_mul)                  state_next = S_MUL;
        else if (accept && is_div && !div_zero) state_next = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      hi        <= '0;
      zero      <= 1'b1;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
      cnt       <= '0;
      reg_a     <= '0;
      reg_hi    <= '0;
      reg_lo    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              reg_a  <= mag1;
              reg_lo <= mag2;
              reg_hi <= '0;
              cnt    <= SHW'(WIDTH - 1);
              neg_q  <= sgn_op && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_r  <= 1'b0;
            end else if (is_div && !div_zero) begin
              reg_a  <= mag2;
              reg_lo <= mag1;
              reg_hi <= '0;
              cnt    <= SHW'(WIDTH - 1);
              neg_q  <= sgn_op && (in1[WIDTH-1] ^ in2[WIDTH-1]);
              neg_r  <= sgn_op && in1[WIDTH-1];
            end else begin
              out       <= res_lo;
              hi        <= res_hi;
              zero      <= (res_lo == '0);
              ovf       <= res_ovf;
              dbz       <= res_dbz;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          reg_hi <= mul_hi_next;
          reg_lo <= mul_lo_next;
          cnt    <= cnt - SHW'(1);
          if (cnt == '0) begin
            out       <= mul_fixed[WIDTH-1:0];
            hi        <= mul_fixed[2*WIDTH-1:WIDTH];
            zero      <= (mul_fixed[WIDTH-1:0] == '0);
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_DIV: begin
          reg_hi <= div_rem_next;
          reg_lo <= div_q_next;
          cnt    <= cnt - SHW'(1);
          if (cnt == '0) begin
            out       <= q_fixed;
            hi        <= r_fixed;
            zero      <= (q_fixed == '0);
            ovf       <= 1'b0;
            dbz       <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
